// File: rtl/pc_pkg.sv
// Shared constants and jump-target helper for the PC sequencer slice.
package pc_pkg;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;

  localparam int unsigned PC_PRIO_NONE       = 0;
  localparam int unsigned PC_PRIO_JUMP       = 1;
  localparam int unsigned PC_PRIO_REDIR_BASE = 2;

  // J-type targets replace the low 28 bits and keep the upper region of pc+4.
  localparam int unsigned PC_JUMP_REGION_LSB = 28;

  function automatic logic [63:0] pc_jump_target(input logic [63:0] pc_plus4,
                                                 input logic [63:0] imm);
    logic [63:0] low_mask;
    low_mask = (64'd1 << PC_JUMP_REGION_LSB) - 64'd1;
    return (pc_plus4 & ~low_mask) | ((imm << 2) & low_mask);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the pipeline control and the PC sequencer.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned NUM_REDIR = 2,
  parameter int unsigned JIMM_W    = 26
);

  logic                          stall;
  logic [NUM_REDIR-1:0]          redir_valid;
  logic [NUM_REDIR*ADDR_W-1:0]   redir_target;
  logic                          jump_valid;
  logic [JIMM_W-1:0]             jump_imm;

  logic [ADDR_W-1:0]             pc;
  logic [ADDR_W-1:0]             pc_plus4;
  logic                          pending;
  logic                          redirect_taken;
  logic                          align_err;

  modport master (
    output stall, redir_valid, redir_target, jump_valid, jump_imm,
    input  pc, pc_plus4, pending, redirect_taken, align_err
  );

  modport slave (
    input  stall, redir_valid, redir_target, jump_valid, jump_imm,
    output pc, pc_plus4, pending, redirect_taken, align_err
  );

endinterface

// File: rtl/pc_redirect_arb.sv
// Combinational priority encoder: none < jump < redirect ch0 < ... < ch(N-1).
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned NUM_REDIR = 2,
  parameter int unsigned PRIO_W    = 2
) (
  input  logic [NUM_REDIR-1:0]        redir_valid,
  input  logic [NUM_REDIR*ADDR_W-1:0] redir_target,
  input  logic                        jump_valid,
  input  logic [ADDR_W-1:0]           jump_target,
  output logic [PRIO_W-1:0]           prio,
  output logic [ADDR_W-1:0]           target
);

  always_comb begin
    prio   = PRIO_W'(PC_PRIO_NONE);
    target = '0;
    if (jump_valid) begin
      prio   = PRIO_W'(PC_PRIO_JUMP);
      target = jump_target;
    end
    // Ascending scan: later (older-stage) channels override earlier ones.
    for (int unsigned k = 0; k < NUM_REDIR; k++) begin
      if (redir_valid[k]) begin
        prio   = PRIO_W'(PC_PRIO_REDIR_BASE + k);
        target = redir_target[k*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with prioritised redirects and a stall-time pending slot.
// Optional PC_ALIGN_CHECK_EN: clear target bits [1:0] and raise sticky align_err.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
  parameter int unsigned       NUM_REDIR = 2,
  parameter int unsigned       JIMM_W    = 26
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  localparam int unsigned PRIO_W = $clog2(NUM_REDIR + 2);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [PRIO_W-1:0] pend_prio_q, pend_prio_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              redirect_taken_q, redirect_taken_d;
`ifdef PC_ALIGN_CHECK_EN
  logic              align_err_q, align_err_d;
`endif

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] jump_target;
  logic [PRIO_W-1:0] live_prio;
  logic [ADDR_W-1:0] live_tgt;
  logic              live_wins;
  logic              sel_used;
  logic [ADDR_W-1:0] sel_tgt;

  assign pc_plus4    = pc_q + ADDR_W'(4);
  assign jump_target = ADDR_W'(pc_jump_target(64'(pc_plus4), 64'(bus.jump_imm)));

  pc_redirect_arb #(
    .ADDR_W    (ADDR_W),
    .NUM_REDIR (NUM_REDIR),
    .PRIO_W    (PRIO_W)
  ) u_arb (
    .redir_valid  (bus.redir_valid),
    .redir_target (bus.redir_target),
    .jump_valid   (bus.jump_valid),
    .jump_target  (jump_target),
    .prio         (live_prio),
    .target       (live_tgt)
  );

  // pend_prio_q is zero whenever nothing is pending, so any live request wins then.
  assign live_wins = live_prio > pend_prio_q;

  always_comb begin
    pc_d             = pc_q;
    pend_d           = pend_q;
    pend_prio_d      = pend_prio_q;
    pend_tgt_d       = pend_tgt_q;
    redirect_taken_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    align_err_d      = align_err_q;
`endif
    sel_used         = 1'b0;
    sel_tgt          = pc_plus4;

    if (live_wins) begin
      sel_used = 1'b1;
      sel_tgt  = live_tgt;
    end else if (pend_q) begin
      sel_used = 1'b1;
      sel_tgt  = pend_tgt_q;
    end

    if (!bus.stall) begin
`ifdef PC_ALIGN_CHECK_EN
      if (sel_used && (sel_tgt[1:0] != 2'b00)) begin
        sel_tgt[1:0] = 2'b00;
        align_err_d  = 1'b1;
      end
`endif
      pc_d             = sel_tgt;
      pend_d           = 1'b0;
      pend_prio_d      = '0;
      redirect_taken_d = sel_used;
    end else if (live_wins) begin
      pend_d      = 1'b1;
      pend_prio_d = live_prio;
      pend_tgt_d  = live_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q             <= RESET_VEC;
      pend_q           <= 1'b0;
      pend_prio_q      <= '0;
      pend_tgt_q       <= '0;
      redirect_taken_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      align_err_q      <= 1'b0;
`endif
    end else begin
      pc_q             <= pc_d;
      pend_q           <= pend_d;
      pend_prio_q      <= pend_prio_d;
      pend_tgt_q       <= pend_tgt_d;
      redirect_taken_q <= redirect_taken_d;
`ifdef PC_ALIGN_CHECK_EN
      align_err_q      <= align_err_d;
`endif
    end
  end

  assign bus.pc             = pc_q;
  assign bus.pc_plus4       = pc_plus4;
  assign bus.pending        = pend_q;
  assign bus.redirect_taken = redirect_taken_q;
`ifdef PC_ALIGN_CHECK_EN
  assign bus.align_err      = align_err_q;
`else
  assign bus.align_err      = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then randomized traffic.
module tb_pc_sequencer;

  localparam int unsigned AW = 32;
  localparam int unsigned NR = 2;
  localparam int unsigned JW = 26;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(AW), .NUM_REDIR(NR), .JIMM_W(JW)) bus ();

  pc_sequencer #(
    .ADDR_W    (AW),
    .RESET_VEC (32'h0000_3000),
    .NUM_REDIR (NR),
    .JIMM_W    (JW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int unsigned due;
    logic [31:0] pc;
    bit          pend;
    bit          rt;
    bit          ae;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // Reference state: what the fetch unit should look like after each edge.
  logic [31:0] m_pc = 32'h0;
  bit          m_pend = 0;
  int          m_pprio = 0;
  logic [31:0] m_ptgt = 32'h0;
  bit          m_rt = 0;
  bit          m_ae = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %08h expected %08h", name, cyc, act, exp);
  endtask

  // Apply one cycle of inputs, advance the reference model, queue the expected state.
  task automatic step(input bit rst, input bit stl, input logic [1:0] rv,
                      input logic [31:0] t0, input logic [31:0] t1,
                      input bit jv, input logic [25:0] ji);
    int          best;
    logic [31:0] best_tgt;
    logic [31:0] load;
    logic [31:0] tgts[2];
    bit          used;
    exp_t        e;
    @(posedge clk);
    #1;
    reset            = rst;
    bus.stall        = stl;
    bus.redir_valid  = rv;
    bus.redir_target = {t1, t0};
    bus.jump_valid   = jv;
    bus.jump_imm     = ji;

    tgts[0] = t0;
    tgts[1] = t1;
    best = 0;
    best_tgt = 32'h0;
    if (jv) begin
      best = 1;
      best_tgt = ((m_pc + 32'd4) & 32'hF000_0000) | {4'h0, ji, 2'b00};
    end
    for (int k = 0; k < 2; k++)
      if (rv[k]) begin
        best = 2 + k;
        best_tgt = tgts[k];
      end

    if (rst) begin
      m_pc = 32'h0000_3000; m_pend = 0; m_pprio = 0; m_rt = 0; m_ae = 0;
    end else if (!stl) begin
      used = 1;
      if (best > m_pprio) load = best_tgt;
      else if (m_pend) load = m_ptgt;
      else begin
        load = m_pc + 32'd4;
        used = 0;
      end
`ifdef PC_ALIGN_CHECK_EN
      if (used && (load % 4 != 0)) begin
        load = load - (load % 4);
        m_ae = 1;
      end
`endif
      m_pc = load; m_pend = 0; m_pprio = 0; m_rt = used;
    end else begin
      if (best > m_pprio) begin
        m_pend = 1; m_pprio = best; m_ptgt = best_tgt;
      end
      m_rt = 0;
    end

    e.due = cyc + 1; e.pc = m_pc; e.pend = m_pend; e.rt = m_rt; e.ae = m_ae;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 32'h0, 32'h0, 0, 26'h0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check("pc", bus.pc, e.pc);
      check("pc_plus4", bus.pc_plus4, e.pc + 32'd4);
      check("pending", 32'(bus.pending), 32'(e.pend));
      check("redirect_taken", 32'(bus.redirect_taken), 32'(e.rt));
      check("align_err", 32'(bus.align_err), 32'(e.ae));
    end
  end

  initial begin
    bus.stall        = 1'b0;
    bus.redir_valid  = '0;
    bus.redir_target = '0;
    bus.jump_valid   = 1'b0;
    bus.jump_imm     = '0;

    // Reset and sequential fetch up to 0x3010.
    step(1, 0, 2'b00, 32'h0, 32'h0, 0, 26'h0);
    idle(4);
    // Jump at 0x3010 to 0x3100.
    step(0, 0, 2'b00, 32'h0, 32'h0, 1, 26'h0000C40);
    idle(1);
    // All channels at once: ch1 wins.
    step(0, 0, 2'b11, 32'h4000, 32'h5000, 1, 26'h0000123);
    // Move to 0x3020, then stall with escalating and dropped requests.
    step(0, 0, 2'b01, 32'h3020, 32'h0, 0, 26'h0);
    step(0, 1, 2'b01, 32'h4000, 32'h0, 0, 26'h0);
    step(0, 1, 2'b10, 32'h0, 32'h6000, 0, 26'h0);
    step(0, 1, 2'b01, 32'h7000, 32'h0, 0, 26'h0);
    idle(2);
    // Pending discarded by reset during stall.
    step(0, 1, 2'b10, 32'h0, 32'h6000, 0, 26'h0);
    step(1, 1, 2'b00, 32'h0, 32'h0, 0, 26'h0);
    idle(2);
    // Misaligned target.
    step(0, 0, 2'b01, 32'h4002, 32'h0, 0, 26'h0);
    idle(2);
    // Wrap of pc+4 at the top of the address space.
    step(0, 0, 2'b10, 32'h0, 32'hFFFF_FFFC, 0, 26'h0);
    idle(2);
    step(1, 0, 2'b00, 32'h0, 32'h0, 0, 26'h0);

    for (int i = 0; i < 800; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 7) != 0) b[1:0] = 2'b00;
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 3,
           2'($urandom_range(0, 3) & $urandom_range(0, 3)),
           a, b, $urandom_range(0, 3) == 0, 26'($urandom));
    end
    idle(1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
